// File: rtl/ex_stage.sv
// Execute stage: forwards operands onto the two ALU inputs, runs the ALU, keeps
// the Z/N/C condition codes, resolves conditional jumps, and registers the
// result and the pass-through controls into the 80-bit EX/MEM buffer.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [91:0] IDEX,
    input  logic [1:0]  Fwd_Sel1,
    input  logic [1:0]  Fwd_Sel2,
    input  logic [15:0] Fwd_EXMEM,
    input  logic [15:0] Fwd_MEMWB,
    input  logic [15:0] InPort,
    input  logic        stall,
    input  logic        flush,
    input  logic        Flags_Restore,
    input  logic [2:0]  Flags_In,
    output logic [79:0] Buffer,
    output logic [2:0]  Flags,
    output logic        Jump_Taken
);

    // Flag bit positions inside {C,N,Z}. A jump condition code FGS of 00/01/10
    // selects Z/N/C, which conveniently matches these bit indices.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    // Single-operand opcodes (OPS=0)
    localparam logic [2:0] OP1_NOT  = 3'b000;
    localparam logic [2:0] OP1_INC  = 3'b001;
    localparam logic [2:0] OP1_DEC  = 3'b010;
    localparam logic [2:0] OP1_MOV  = 3'b011;
    localparam logic [2:0] OP1_SETC = 3'b100;
    localparam logic [2:0] OP1_CLRC = 3'b101;

    // Two-operand opcodes (OPS=1)
    localparam logic [2:0] OP2_ADD  = 3'b000;
    localparam logic [2:0] OP2_SUB  = 3'b001;
    localparam logic [2:0] OP2_AND  = 3'b010;
    localparam logic [2:0] OP2_OR   = 3'b011;
    localparam logic [2:0] OP2_SHL  = 3'b100;
    localparam logic [2:0] OP2_SHR  = 3'b101;
    localparam logic [2:0] OP2_PB   = 3'b110;

    // ------------------------------------------------------------------
    // ID/EX field decode
    // ------------------------------------------------------------------
    logic        ior;
    logic        iow;
    logic        ops;
    logic [2:0]  alu_op;
    logic        alu_en;
    logic [1:0]  fd;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  wb_address;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        jmp;
    logic        sp;
    logic        spop;
    logic [1:0]  fgs;
    logic [31:0] pc;
    logic        jwsp;
    logic [2:0]  src_address;
    logic        imm;
    logic        stack_pc;
    logic        stack_flags;
    logic        intr;

    assign ior         = IDEX[0];
    assign iow         = IDEX[1];
    assign ops         = IDEX[2];
    assign alu_op      = IDEX[5:3];
    assign alu_en      = IDEX[6];
    assign fd          = IDEX[8:7];
    assign data1       = IDEX[24:9];
    assign data2       = IDEX[40:25];
    assign wb_address  = IDEX[43:41];
    assign mr          = IDEX[44];
    assign mw          = IDEX[45];
    assign wb          = IDEX[46];
    assign jmp         = IDEX[47];
    assign sp          = IDEX[48];
    assign spop        = IDEX[49];
    assign fgs         = IDEX[51:50];
    assign pc          = IDEX[83:52];
    assign jwsp        = IDEX[84];
    assign src_address = IDEX[87:85];
    assign imm         = IDEX[88];
    assign stack_pc    = IDEX[89];
    assign stack_flags = IDEX[90];
    assign intr        = IDEX[91];

    // FD and SRC_Address are only meaningful to the hazard unit upstream.
    logic unused_fields;
    assign unused_fields = ^{fd, src_address};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [79:0] buffer_reg;
    logic [79:0] buffer_next;
    logic [2:0]  flags_reg;
    logic [2:0]  flags_next;

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] op2_fwd;

    // Select operand 1; code 11 falls back to the ID/EX value.
    always_comb begin
        op1 = data1;
        case (Fwd_Sel1)
            2'b01:   op1 = Fwd_EXMEM;
            2'b10:   op1 = Fwd_MEMWB;
            default: op1 = data1;
        endcase
    end

    // Select operand 2; an immediate always comes straight from Data2.
    always_comb begin
        op2_fwd = data2;
        case (Fwd_Sel2)
            2'b01:   op2_fwd = Fwd_EXMEM;
            2'b10:   op2_fwd = Fwd_MEMWB;
            default: op2_fwd = data2;
        endcase
        op2 = imm ? data2 : op2_fwd;
    end

    // ------------------------------------------------------------------
    // Arithmetic helpers (17 bits wide so carry/borrow falls out in bit 16)
    // ------------------------------------------------------------------
    logic [16:0] add_wide;
    logic [16:0] sub_wide;
    logic [16:0] inc_wide;
    logic [16:0] dec_wide;
    logic [16:0] shl_wide;
    logic [16:0] shr_wide;
    logic [3:0]  shamt;

    assign add_wide = {1'b0, op1} + {1'b0, op2};
    assign sub_wide = {1'b0, op1} - {1'b0, op2};
    assign inc_wide = {1'b0, op1} + 17'd1;
    assign dec_wide = {1'b0, op1} - 17'd1;
    assign shamt    = op2[3:0];
    // The extra bit catches the last bit shifted out: bit 16 for a left
    // shift, bit 0 for a right shift.
    assign shl_wide = {1'b0, op1} << shamt;
    assign shr_wide = {op1, 1'b0} >> shamt;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [15:0] alu_result;
    logic        upd_zn;
    logic        upd_c;
    logic        c_val;

    // Compute the ALU result and which flags this opcode is allowed to touch.
    always_comb begin
        alu_result = op1;
        upd_zn     = 1'b0;
        upd_c      = 1'b0;
        c_val      = 1'b0;
        if (alu_en) begin
            if (!ops) begin
                case (alu_op)
                    OP1_NOT: begin
                        alu_result = ~op1;
                        upd_zn     = 1'b1;
                    end
                    OP1_INC: begin
                        alu_result = inc_wide[15:0];
                        upd_zn     = 1'b1;
                        upd_c      = 1'b1;
                        c_val      = inc_wide[16];
                    end
                    OP1_DEC: begin
                        alu_result = dec_wide[15:0];
                        upd_zn     = 1'b1;
                        upd_c      = 1'b1;
                        c_val      = dec_wide[16];
                    end
                    OP1_MOV: begin
                        alu_result = op1;
                    end
                    OP1_SETC: begin
                        upd_c = 1'b1;
                        c_val = 1'b1;
                    end
                    OP1_CLRC: begin
                        upd_c = 1'b1;
                        c_val = 1'b0;
                    end
                    default: begin
                        alu_result = op1;
                    end
                endcase
            end else begin
                case (alu_op)
                    OP2_ADD: begin
                        alu_result = add_wide[15:0];
                        upd_zn     = 1'b1;
                        upd_c      = 1'b1;
                        c_val      = add_wide[16];
                    end
                    OP2_SUB: begin
                        alu_result = sub_wide[15:0];
                        upd_zn     = 1'b1;
                        upd_c      = 1'b1;
                        c_val      = sub_wide[16];
                    end
                    OP2_AND: begin
                        alu_result = op1 & op2;
                        upd_zn     = 1'b1;
                    end
                    OP2_OR: begin
                        alu_result = op1 | op2;
                        upd_zn     = 1'b1;
                    end
                    OP2_SHL: begin
                        alu_result = shl_wide[15:0];
                        upd_zn     = 1'b1;
                        // A zero-distance shift has no "last bit out".
                        upd_c      = (shamt != 4'd0);
                        c_val      = shl_wide[16];
                    end
                    OP2_SHR: begin
                        alu_result = shr_wide[16:1];
                        upd_zn     = 1'b1;
                        upd_c      = (shamt != 4'd0);
                        c_val      = shr_wide[0];
                    end
                    OP2_PB: begin
                        alu_result = op2;
                    end
                    default: begin
                        alu_result = op1;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Jump resolution
    // ------------------------------------------------------------------
    // Test the condition selected by FGS against the current flags.
    always_comb begin
        Jump_Taken = 1'b0;
        if (jmp) begin
            case (fgs)
                2'b00:   Jump_Taken = flags_reg[FLAG_Z];
                2'b01:   Jump_Taken = flags_reg[FLAG_N];
                2'b10:   Jump_Taken = flags_reg[FLAG_C];
                default: Jump_Taken = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flag update
    // ------------------------------------------------------------------
    logic [2:0] flags_exec;

    // Merge ALU flag effects and the taken-jump clear; then apply the
    // restore/flush/stall priority on top.
    always_comb begin
        flags_exec = flags_reg;
        if (upd_zn) begin
            flags_exec[FLAG_Z] = (alu_result == 16'h0000);
            flags_exec[FLAG_N] = alu_result[15];
        end
        if (upd_c) begin
            flags_exec[FLAG_C] = c_val;
        end
        // A taken conditional jump consumes the flag it tested.
        if (Jump_Taken && (fgs != 2'b11)) begin
            flags_exec[fgs] = 1'b0;
        end

        if (Flags_Restore) begin
            flags_next = Flags_In;
        end else if (flush || stall) begin
            flags_next = flags_reg;
        end else begin
            flags_next = flags_exec;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM buffer assembly
    // ------------------------------------------------------------------
    logic [15:0] result;

    // Input-port reads override whatever the ALU produced.
    assign result = ior ? InPort : alu_result;

    // Pack the outgoing EX/MEM word, or hold/bubble it.
    always_comb begin
        if (flush) begin
            buffer_next = '0;
        end else if (stall) begin
            buffer_next = buffer_reg;
        end else begin
            buffer_next = {
                flags_reg,      // FlagSnap [79:77]
                iow,            // [76]
                intr,           // [75]
                stack_flags,    // [74]
                stack_pc,       // [73]
                jwsp,           // [72]
                pc,             // [71:40]
                spop,           // [39]
                sp,             // [38]
                wb,             // [37]
                mw,             // [36]
                mr,             // [35]
                wb_address,     // [34:32]
                op1,            // StoreData [31:16]
                result          // [15:0]
            };
        end
    end

    // EX/MEM and flag registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer_reg <= '0;
            flags_reg  <= '0;
        end else begin
            buffer_reg <= buffer_next;
            flags_reg  <= flags_next;
        end
    end

    assign Buffer = buffer_reg;
    assign Flags  = flags_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: each directed instruction pushes its expected
// EX/MEM word and flags (and optionally Jump_Taken); independent monitors pop
// and compare as the DUT presents each result.
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [91:0] IDEX;
    logic [1:0]  Fwd_Sel1;
    logic [1:0]  Fwd_Sel2;
    logic [15:0] Fwd_EXMEM;
    logic [15:0] Fwd_MEMWB;
    logic [15:0] InPort;
    logic        stall;
    logic        flush;
    logic        Flags_Restore;
    logic [2:0]  Flags_In;
    logic [79:0] Buffer;
    logic [2:0]  Flags;
    logic        Jump_Taken;

    ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .IDEX         (IDEX),
        .Fwd_Sel1     (Fwd_Sel1),
        .Fwd_Sel2     (Fwd_Sel2),
        .Fwd_EXMEM    (Fwd_EXMEM),
        .Fwd_MEMWB    (Fwd_MEMWB),
        .InPort       (InPort),
        .stall        (stall),
        .flush        (flush),
        .Flags_Restore(Flags_Restore),
        .Flags_In     (Flags_In),
        .Buffer       (Buffer),
        .Flags        (Flags),
        .Jump_Taken   (Jump_Taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] NOT_ = 3'b000, INC = 3'b001, DEC = 3'b010, MOV = 3'b011;
    localparam logic [2:0] SETC = 3'b100, CLRC = 3'b101;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101;

    typedef struct packed {
        logic [79:0] b;
        logic [2:0]  f;
    } exp_t;

    exp_t sb_q[$];
    logic jt_q[$];

    int passed = 0;
    int total  = 0;
    int txn    = 0;

    logic [79:0] last_buf;
    logic [2:0]  last_flags;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Build an ID/EX word; tag scatters recognisable bits over the pass-through fields.
    function automatic logic [91:0] mk(input logic ior, input logic ops, input logic [2:0] op,
                                       input logic alu, input logic [15:0] d1, input logic [15:0] d2,
                                       input logic imm, input logic jmp, input logic [1:0] fgs,
                                       input logic [7:0] tag);
        logic [91:0] v;
        v = '0;
        v[0] = ior; v[1] = tag[4]; v[2] = ops; v[5:3] = op; v[6] = alu;
        v[8:7] = tag[1:0]; v[24:9] = d1; v[40:25] = d2; v[43:41] = tag[2:0];
        v[44] = tag[3]; v[45] = tag[4]; v[46] = tag[5]; v[47] = jmp;
        v[48] = tag[6]; v[49] = tag[7]; v[51:50] = fgs;
        v[83:52] = {8'hA5, tag, 8'h00, ~tag};
        v[84] = tag[0]; v[87:85] = tag[7:5]; v[88] = imm;
        v[89] = tag[1]; v[90] = tag[2]; v[91] = tag[3];
        return v;
    endfunction

    // Expected EX/MEM word from a result, store data, the issued ID/EX word and the pre-update flags.
    function automatic logic [79:0] mkbuf(input logic [15:0] res, input logic [15:0] sd,
                                          input logic [91:0] v, input logic [2:0] snap);
        logic [79:0] b;
        b = '0;
        b[15:0] = res; b[31:16] = sd; b[34:32] = v[43:41];
        b[35] = v[44]; b[36] = v[45]; b[37] = v[46]; b[38] = v[48]; b[39] = v[49];
        b[71:40] = v[83:52]; b[72] = v[84]; b[73] = v[89]; b[74] = v[90];
        b[75] = v[91]; b[76] = v[1]; b[79:77] = snap;
        return b;
    endfunction

    task automatic defaults();
        Fwd_Sel1 = 2'b00; Fwd_Sel2 = 2'b00;
        Fwd_EXMEM = 16'hAAAA; Fwd_MEMWB = 16'h5555; InPort = 16'h0F0F;
        stall = 1'b0; flush = 1'b0; Flags_Restore = 1'b0; Flags_In = 3'b111;
    endtask

    task automatic nxt();
        @(negedge clk);
        defaults();
    endtask

    // Drive one instruction and push its expectations; jt<0 means no jump check.
    task automatic issue(input logic [91:0] v, input logic st, input logic fl,
                         input logic [15:0] res, input logic [15:0] sd,
                         input logic [2:0] fexp, input int jt);
        exp_t e;
        IDEX = v; stall = st; flush = fl;
        if (fl)      e.b = '0;
        else if (st) e.b = last_buf;
        else         e.b = mkbuf(res, sd, v, last_flags);
        e.f = fexp;
        sb_q.push_back(e);
        if (jt >= 0) jt_q.push_back(jt[0]);
        last_buf   = e.b;
        last_flags = fexp;
    endtask

    // Monitor: compare the registered outputs just after each active edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            txn++;
            chk($sformatf("buffer#%0d", txn), Buffer, mon_e.b);
            chk($sformatf("flags#%0d", txn), {77'b0, Flags}, {77'b0, mon_e.f});
            $display("txn %0d: Buffer=%h Flags=%b", txn, Buffer, Flags);
        end
    end

    // Monitor: Jump_Taken is combinational, so sample it mid-cycle.
    logic mon_jt;
    always @(negedge clk) begin
        #2;
        if (jt_q.size() > 0) begin
            mon_jt = jt_q.pop_front();
            chk("jump_taken", {79'b0, Jump_Taken}, {79'b0, mon_jt});
            $display("jump check: Jump_Taken=%b", Jump_Taken);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        IDEX  = '0;
        defaults();
        last_buf = '0;
        last_flags = 3'b000;
        #2;
        chk("reset_buffer", Buffer, 80'b0);
        chk("reset_flags", {77'b0, Flags}, 80'b0);

        // Leave reset and load some nonzero state
        @(negedge clk);
        reset = 1'b1;
        defaults();
        issue(mk(0,1,ADD,1,16'hFFFF,16'h0001,0,0,2'b00,8'h3C), 0,0, 16'h0000,16'hFFFF, 3'b101, -1);

        // Asynchronous reset away from any clock edge
        nxt();
        IDEX = '0;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_buffer", Buffer, 80'b0);
        chk("async_reset_flags", {77'b0, Flags}, 80'b0);
        last_buf = '0;
        last_flags = 3'b000;

        nxt(); reset = 1'b1;
        issue(mk(0,1,ADD,1,16'h0003,16'h0004,0,0,2'b00,8'h11), 0,0, 16'h0007,16'h0003, 3'b000, -1);
        nxt(); issue(mk(0,1,ADD,1,16'hFFFF,16'h0001,0,0,2'b00,8'h22), 0,0, 16'h0000,16'hFFFF, 3'b101, -1);
        nxt(); issue(mk(0,1,SUB,1,16'h0002,16'h0005,0,0,2'b00,8'h33), 0,0, 16'hFFFD,16'h0002, 3'b110, -1);

        // Forwarding into op1, immediate overrides op2 forwarding
        nxt(); Fwd_Sel1 = 2'b01; Fwd_EXMEM = 16'h1234; Fwd_Sel2 = 2'b10; Fwd_MEMWB = 16'hBEEF;
        issue(mk(0,1,ADD,1,16'h5555,16'h0001,1,0,2'b00,8'h44), 0,0, 16'h1235,16'h1234, 3'b000, -1);
        // Select code 11 uses the ID/EX value
        nxt(); Fwd_Sel1 = 2'b11; Fwd_EXMEM = 16'h7777;
        issue(mk(0,1,ADD,1,16'h0000,16'h0000,0,0,2'b00,8'h55), 0,0, 16'h0000,16'h0000, 3'b001, -1);

        // Jumps
        nxt(); issue(mk(0,0,3'b000,0,16'h00AA,16'h0000,0,1,2'b00,8'h66), 0,0, 16'h00AA,16'h00AA, 3'b000, 1);
        nxt(); issue(mk(0,0,NOT_,1,16'h7FFF,16'h0000,0,0,2'b00,8'h77), 0,0, 16'h8000,16'h7FFF, 3'b010, -1);
        nxt(); issue(mk(0,0,3'b000,0,16'h0BBB,16'h0000,0,1,2'b10,8'h88), 0,0, 16'h0BBB,16'h0BBB, 3'b010, 0);
        nxt(); issue(mk(0,0,3'b000,0,16'h0CCC,16'h0000,0,1,2'b01,8'h99), 0,0, 16'h0CCC,16'h0CCC, 3'b000, 1);
        nxt(); issue(mk(0,1,ADD,1,16'hFFFF,16'h0002,0,0,2'b00,8'hAA), 0,0, 16'h0001,16'hFFFF, 3'b100, -1);
        nxt(); issue(mk(0,0,3'b000,0,16'h0DDD,16'h0000,0,1,2'b11,8'hBB), 0,0, 16'h0DDD,16'h0DDD, 3'b100, 1);
        nxt(); issue(mk(0,0,3'b000,0,16'h0EEE,16'h0000,0,1,2'b10,8'hCC), 0,0, 16'h0EEE,16'h0EEE, 3'b000, 1);

        // Stall holds, flush bubbles
        nxt(); issue(mk(0,1,ADD,1,16'hFFFF,16'hFFFF,0,0,2'b00,8'hDD), 1,0, 16'h0000,16'h0000, 3'b000, -1);
        nxt(); issue(mk(0,0,SETC,1,16'h1357,16'h0000,0,0,2'b00,8'hEE), 0,1, 16'h0000,16'h0000, 3'b000, -1);

        // Flag restore wins over a stalled CLRC
        nxt(); Flags_Restore = 1'b1; Flags_In = 3'b011;
        issue(mk(0,0,CLRC,1,16'h2468,16'h0000,0,0,2'b00,8'h0F), 1,0, 16'h0000,16'h0000, 3'b011, -1);

        // Shifts
        nxt(); issue(mk(0,1,SHL,1,16'h8001,16'h0001,0,0,2'b00,8'h1E), 0,0, 16'h0002,16'h8001, 3'b100, -1);
        nxt(); issue(mk(0,1,SHR,1,16'h0009,16'h0004,0,0,2'b00,8'h2D), 0,0, 16'h0000,16'h0009, 3'b101, -1);
        nxt(); issue(mk(0,1,SHL,1,16'h8000,16'h0010,0,0,2'b00,8'h3B), 0,0, 16'h8000,16'h8000, 3'b110, -1);

        // INC/DEC/logic/IO
        nxt(); issue(mk(0,0,DEC,1,16'h0000,16'h0000,0,0,2'b00,8'h4A), 0,0, 16'hFFFF,16'h0000, 3'b110, -1);
        nxt(); issue(mk(0,0,INC,1,16'hFFFF,16'h0000,0,0,2'b00,8'h59), 0,0, 16'h0000,16'hFFFF, 3'b101, -1);
        nxt(); issue(mk(0,1,AND_,1,16'hF0F0,16'h0F0F,0,0,2'b00,8'h68), 0,0, 16'h0000,16'hF0F0, 3'b101, -1);
        nxt(); issue(mk(0,1,OR_,1,16'h8000,16'h0001,0,0,2'b00,8'h77), 0,0, 16'h8001,16'h8000, 3'b110, -1);
        nxt(); InPort = 16'hCAFE;
        issue(mk(1,0,MOV,1,16'h1111,16'h0000,0,0,2'b00,8'h86), 0,0, 16'hCAFE,16'h1111, 3'b110, -1);
        nxt(); issue(mk(0,1,SUB,1,16'h0005,16'h0005,0,0,2'b00,8'h95), 0,0, 16'h0000,16'h0005, 3'b001, -1);

        // Drain
        nxt(); IDEX = '0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 80'(sb_q.size()), 80'd0);
        chk("jump_queue_drained", 80'(jt_q.size()), 80'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
